dff_pipeline: RTL and testbench

//  Parametrised successor to the single-bit D flip-flop: an elastic chain of DEPTH

---
 rtl/dff_pipeline.sv | 121 ++++++++++++
 tb/tb_dff_pipeline.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline.sv
// Elastic register chain: DEPTH stages of WIDTH bits with per-stage valids,
// valid/ready handshakes on both ends, synchronous flush and an occupancy count.

module dff_pipeline_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             adv_i,
    input  logic             prev_v_i,
    input  logic [WIDTH-1:0] prev_d_i,
    output logic             v_o,
    output logic             v_nxt_o,
    output logic [WIDTH-1:0] d_o
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // The data register only loads when a real beat moves in; bubbles leave it stale.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (adv_i) begin
            v_d = prev_v_i;
            if (prev_v_i) d_d = prev_d_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= 1'b0;
            d_q <= RST_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o     = v_q;
    assign v_nxt_o = v_d;
    assign d_o     = d_q;
endmodule

module dff_pipeline #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v_q, v_nxt, adv, prev_v;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, prev_d;
    logic [CW-1:0]               occ_q, occ_d;

    // A stage moves when it is empty or its successor moves; ripples back from out_ready.
    always_comb begin : adv_chain
        logic acc;
        adv = '0;
        acc = ~v_q[DEPTH-1] | out_ready;
        adv[DEPTH-1] = acc;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            acc    = ~v_q[i] | acc;
            adv[i] = acc;
        end
    end

    always_comb begin
        prev_v    = '0;
        prev_d    = '0;
        prev_v[0] = in_valid;
        prev_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            prev_v[i] = v_q[i-1];
            prev_d[i] = d_q[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_pipeline_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush_i  (flush),
            .adv_i    (adv[i]),
            .prev_v_i (prev_v[i]),
            .prev_d_i (prev_d[i]),
            .v_o      (v_q[i]),
            .v_nxt_o  (v_nxt[i]),
            .d_o      (d_q[i])
        );
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) occ_d = occ_d + CW'(v_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;
endmodule

// File: tb/tb_dff_pipeline.sv
// Scoreboard bench: a FIFO model per instance predicts data order, occupancy and in_ready.
module tb_dff_pipeline;
    localparam int          NCFG = 3;
    localparam int          WS  [NCFG] = '{8, 1, 32};
    localparam int          DS  [NCFG] = '{4, 1, 8};
    localparam logic [31:0] RVS [NCFG] = '{32'h3C, 32'h0, 32'h0};

    logic clk;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g
        localparam int          W  = WS[k];
        localparam int          D  = DS[k];
        localparam int          CW = $clog2(D + 1);
        localparam logic [W-1:0] RV = W'(RVS[k]);

        logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
        logic [W-1:0]  in_data, out_data;
        logic [CW-1:0] occ;
        logic [W-1:0]  q[$];

        dff_pipeline #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
            .clk       (clk),
            .reset     (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .occupancy (occ)
        );

        // Monitor: inputs are stable mid-cycle, so the handshakes of the coming edge are known here.
        always @(negedge clk) begin
            if (!rst) begin
                q.delete();
                chk($sformatf("c%0d_rst_out_valid", k), 32'(out_valid), 32'd0);
                chk($sformatf("c%0d_rst_out_data", k), 32'(out_data), 32'(RV));
                chk($sformatf("c%0d_rst_occupancy", k), 32'(occ), 32'd0);
            end else begin
                chk($sformatf("c%0d_occupancy", k), 32'(occ), 32'(q.size()));
                chk($sformatf("c%0d_in_ready", k), 32'(in_ready),
                    32'(!flush && (q.size() < D || out_ready)));
                if (out_valid && q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL c%0d_spurious_out: actual out_data %0h required no output", k, out_data);
                end
                if (flush) begin
                    q.delete();
                end else begin
                    if (out_valid && out_ready && q.size() > 0)
                        chk($sformatf("c%0d_out_data", k), 32'(out_data), 32'(q.pop_front()));
                    if (in_valid && in_ready) q.push_back(in_data);
                end
            end
        end

        if (k == 0) begin : g_dir
            initial begin
                int  idx;
                logic acc;
                rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
                repeat (3) tick();
                rst = 1'b1; in_valid = 1'b0;
                tick();
                // streaming, fixed latency of D cycles
                out_ready = 1'b1;
                for (int t = 0; t < 12; t++) begin
                    in_valid = (t < 8);
                    in_data  = W'(t + 1);
                    @(negedge clk);
                    if (t < 8) chk("stream_in_ready", 32'(in_ready), 32'd1);
                    chk("stream_out_valid", 32'(out_valid), 32'(t >= 4));
                    if (t >= 4) chk("stream_out_data", 32'(out_data), 32'(t - 3));
                    tick();
                end
                in_valid = 1'b0;
                repeat (4) tick();
                // backpressure
                out_ready = 1'b0;
                idx = 0;
                for (int c = 0; c < 6; c++) begin
                    in_valid = 1'b1; in_data = W'(8'h10 + idx);
                    @(negedge clk); acc = in_ready;
                    tick();
                    if (acc) idx++;
                end
                chk("bp_accepted", 32'(idx), 32'd4);
                @(negedge clk);
                chk("bp_full_occ", 32'(occ), 32'd4);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                tick();
                out_ready = 1'b1;
                for (int c = 0; c < 20 && idx < 6; c++) begin
                    in_valid = 1'b1; in_data = W'(8'h10 + idx);
                    @(negedge clk); acc = in_ready;
                    tick();
                    if (acc) idx++;
                end
                chk("bp_all_sent", 32'(idx), 32'd6);
                in_valid = 1'b0;
                repeat (10) tick();
                chk("bp_drained", 32'(q.size()), 32'd0);
                // full pass-through
                out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    in_valid = 1'b1; in_data = W'(8'h20 + c);
                    tick();
                end
                out_ready = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    in_data = W'(8'h24 + c);
                    @(negedge clk);
                    chk("pass_in_ready", 32'(in_ready), 32'd1);
                    chk("pass_out_valid", 32'(out_valid), 32'd1);
                    chk("pass_occ", 32'(occ), 32'd4);
                    tick();
                end
                in_valid = 1'b0;
                repeat (8) tick();
                // flush with three resident beats and a competing input
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    in_valid = 1'b1; in_data = W'(8'h30 + c);
                    tick();
                end
                in_valid = 1'b0;
                tick();
                flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
                @(negedge clk);
                chk("flush_in_ready", 32'(in_ready), 32'd0);
                tick();
                flush = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                chk("flush_occ", 32'(occ), 32'd0);
                chk("flush_out_valid", 32'(out_valid), 32'd0);
                tick();
                out_ready = 1'b1;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    chk("flush_no_output", 32'(out_valid), 32'd0);
                    tick();
                end
                // asynchronous reset mid-cycle with data resident
                out_ready = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    in_valid = 1'b1; in_data = W'(8'h40 + c);
                    tick();
                end
                in_valid = 1'b0;
                repeat (3) tick();
                @(negedge clk);
                chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
                tick();
                #2 rst = 1'b0;
                #1;
                chk("async_out_valid", 32'(out_valid), 32'd0);
                chk("async_out_data", 32'(out_data), 32'(RV));
                chk("async_occ", 32'(occ), 32'd0);
                tick();
                tick();
                rst = 1'b1;
                repeat (3) tick();
                n_done++;
            end
        end else begin : g_rnd
            initial begin
                rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
                repeat (3) tick();
                rst = 1'b1;
                out_ready = 1'b1;
                for (int c = 0; c < 100; c++) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = W'($urandom);
                    tick();
                end
                out_ready = 1'b0;
                for (int c = 0; c < D + 3; c++) begin
                    in_valid = 1'b1;
                    in_data  = W'($urandom);
                    tick();
                end
                @(negedge clk);
                chk($sformatf("c%0d_full_occ", k), 32'(occ), 32'(D));
                chk($sformatf("c%0d_full_in_ready", k), 32'(in_ready), 32'd0);
                tick();
                for (int c = 0; c < 300; c++) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    out_ready = 1'($urandom_range(0, 1));
                    flush     = ($urandom_range(0, 31) == 0);
                    in_data   = W'($urandom);
                    tick();
                end
                flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
                repeat (2 * D + 4) tick();
                @(negedge clk);
                #1;
                chk($sformatf("c%0d_drained", k), 32'(q.size()), 32'd0);
                n_done++;
            end
        end
    end

    initial begin
        for (int c = 0; c < 20000 && n_done < NCFG; c++) @(posedge clk);
        chk("all_done", 32'(n_done), 32'(NCFG));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
